// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters and rr_arbiter8.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if #(
    parameter int N    = 8,
    parameter int IDXW = 3
);
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter, grant held until the owner releases.
// RR_ARB_TIMEOUT_EN adds a forced release after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int N    = 8,
    parameter int IDXW = 3
`ifdef RR_ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input logic          clk,
    input logic          rst,
    rr_arbiter8_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]      state;
    logic [IDXW-1:0] ptr;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            tmo;

    logic [N-1:0]    cand;
    logic [2*N-1:0]  rot_wide;
    logic [N-1:0]    rot;
    logic [IDXW-1:0] off;
    logic [IDXW-1:0] win;
    logic            found;
    logic            rel;
    logic            load;

    // Rotate so bit 0 is the ptr position, pick the lowest set bit, rotate back.
    always_comb begin
        rel      = bus.done[gnt_idx] | ~bus.req[gnt_idx] | tmo;
        cand     = (state == GRANT) ? (bus.req & ~gnt) : bus.req;
        rot_wide = {cand, cand} >> ptr;
        rot      = rot_wide[N-1:0];
        found    = |rot;
        off      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDXW'(i);
        end
        win  = ptr + off;
        load = found & ((state == IDLE) | rel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        gnt       <= ONE << win;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        ptr       <= win + 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (load) begin
                        gnt     <= ONE << win;
                        gnt_idx <= win;
                        ptr     <= win + 1'b1;
                    end else if (rel) begin
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;

    logic [CW-1:0] hold_cnt;
    logic          timeout_q;

    assign tmo = (state == GRANT) &&
                 (hold_cnt == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo;
            if (load || rel)
                hold_cnt <= '0;
            else if (state == GRANT)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign tmo         = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt       = gnt;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_valid = gnt_valid;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: vector table, directed corner sequences and a
// randomized run against a queue-free behavioural round-robin model.
module tb_rr_arbiter8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_arbiter8_if bus ();

`ifdef RR_ARB_TIMEOUT_EN
    localparam int MAXH = 4;
    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
`else
    rr_arbiter8 dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] oh;
        oh = 8'd1 << bus.gnt_idx;
        check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        check("valid_eq_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
        if (bus.gnt_valid)
            check("idx_match", 32'(bus.gnt), 32'(oh));
        else
            check("idx_zero", 32'(bus.gnt_idx), 32'd0);
    end

    // Reference model: owner index (-1 = none), next-priority pointer.
    int m_own = -1;
    int m_ptr = 0;
    int m_hold = 0;
    bit m_to = 0;

    function automatic int pick(input logic [7:0] r, input int skip);
        int res;
        res = -1;
        for (int i = 7; i >= 0; i--) begin
            int k;
            k = (m_ptr + i) % 8;
            if (k != skip && r[k]) res = k;
        end
        return res;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [7:0] r,
                              input logic [7:0] d);
        int w;
        bit rl;
        m_to = 0;
        if (r_rst) begin
            m_own = -1;
            m_ptr = 0;
            m_hold = 0;
        end else if (m_own < 0) begin
            w = pick(r, -1);
            if (w >= 0) begin
                m_own = w;
                m_ptr = (w + 1) % 8;
                m_hold = 0;
            end
        end else begin
            rl = d[m_own] || !r[m_own];
`ifdef RR_ARB_TIMEOUT_EN
            if (m_hold == MAXH - 1) begin
                rl = 1;
                m_to = 1;
            end
`endif
            if (rl) begin
                w = pick(r, m_own);
                m_own = w;
                m_hold = 0;
                if (w >= 0) m_ptr = (w + 1) % 8;
            end else begin
                m_hold++;
            end
        end
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic       r_rst;
        logic [7:0] r_req;
        logic [7:0] r_done;
        logic [7:0] e_gnt;

        tbl[0]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 8'h01, 8'h00, 8'h01, 3'd0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 8'h01, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'h08, 8'h00, 8'h08, 3'd3, 1'b1};
        tbl[5]  = '{1'b0, 8'h0C, 8'h04, 8'h08, 3'd3, 1'b1};
        tbl[6]  = '{1'b0, 8'h0C, 8'h00, 8'h08, 3'd3, 1'b1};
        tbl[7]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1};
        tbl[8]  = '{1'b0, 8'h04, 8'h04, 8'h00, 3'd0, 1'b0};
        tbl[9]  = '{1'b0, 8'h20, 8'h00, 8'h20, 3'd5, 1'b1};
        tbl[10] = '{1'b0, 8'h21, 8'h20, 8'h01, 3'd0, 1'b1};
        tbl[11] = '{1'b0, 8'h21, 8'h00, 8'h01, 3'd0, 1'b1};
        tbl[12] = '{1'b0, 8'h21, 8'h01, 8'h20, 3'd5, 1'b1};
        tbl[13] = '{1'b0, 8'h21, 8'hDF, 8'h20, 3'd5, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[16] = '{1'b0, 8'h40, 8'h00, 8'h40, 3'd6, 1'b1};
        tbl[17] = '{1'b1, 8'h40, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[18] = '{1'b0, 8'h82, 8'h00, 8'h02, 3'd1, 1'b1};

        bus.req  = 8'h00;
        bus.done = 8'h00;

        foreach (tbl[i]) begin
            rst      = tbl[i].rst;
            bus.req  = tbl[i].req;
            bus.done = tbl[i].done;
            tick();
            check($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_idx", i), 32'(bus.gnt_idx), 32'(tbl[i].idx));
            check($sformatf("tbl%0d_vld", i), 32'(bus.gnt_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d_to", i), 32'(bus.timeout), 32'd0);
        end

        // All requesting, owner releases every second cycle.
        rst = 1'b1; bus.req = 8'hFF; bus.done = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        check("rr_first", 32'(bus.gnt_idx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            bus.done = 8'h00;
            tick();
            check($sformatf("rr_hold%0d", k), 32'(bus.gnt_idx), 32'(k));
            bus.done = 8'd1 << k;
            tick();
            check($sformatf("rr_next%0d", k), 32'(bus.gnt_idx), 32'((k + 1) % 8));
            check($sformatf("rr_vld%0d", k), 32'(bus.gnt_valid), 32'd1);
        end
        bus.done = 8'h00;

        // Owner never releases.
        rst = 1'b1; bus.req = 8'h03;
        tick();
        rst = 1'b0;
        tick();
        check("hold_first", 32'(bus.gnt), 32'h01);
`ifdef RR_ARB_TIMEOUT_EN
        for (int k = 0; k < MAXH - 1; k++) begin
            tick();
            check("tmo_hold", 32'(bus.gnt), 32'h01);
            check("tmo_quiet", 32'(bus.timeout), 32'd0);
        end
        tick();
        check("tmo_next", 32'(bus.gnt), 32'h02);
        check("tmo_pulse", 32'(bus.timeout), 32'd1);
        tick();
        check("tmo_pulse_end", 32'(bus.timeout), 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            check("hold_gnt", 32'(bus.gnt), 32'h01);
            check("hold_to", 32'(bus.timeout), 32'd0);
        end
`endif

        // Randomized run against the model.
        rst = 1'b1; bus.req = 8'h00; bus.done = 8'h00;
        model_edge(1'b1, 8'h00, 8'h00);
        tick();
        r_req = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0)
                r_req = 8'($urandom) & 8'($urandom);
            r_done = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rst = r_rst; bus.req = r_req; bus.done = r_done;
            model_edge(r_rst, r_req, r_done);
            tick();
            e_gnt = (m_own < 0) ? 8'h00 : (8'd1 << m_own);
            check("rnd_gnt", 32'(bus.gnt), 32'(e_gnt));
            check("rnd_idx", 32'(bus.gnt_idx), (m_own < 0) ? 32'd0 : 32'(m_own));
            check("rnd_vld", 32'(bus.gnt_valid), 32'(m_own >= 0));
            check("rnd_to", 32'(bus.timeout), 32'(m_to));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
